// File: rtl/cpu_defs_pkg.sv
// rtl/cpu_defs_pkg.sv - shared encodings for the PC fetch stage
package cpu_defs_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_J   = 2'b10;
    localparam logic [1:0] PCSRC_RSV = 2'b11;

    localparam logic [5:0] HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - control-unit facing bundle of the PC fetch stage
interface pc_fetch_unit_if #(
    parameter int CNT_W = 32
);
    logic             PCWre;
    logic [1:0]       PCSrc;
    logic             stall;
    logic [31:0]      immExt;
    logic [25:0]      jAddr;
    logic [31:0]      curPC;
    logic [31:0]      pcPlus4;
    logic [31:0]      nextPC;
    logic             halted;
    logic             pcErr;
    logic [CNT_W-1:0] instCount;

    modport master (
        output PCWre, PCSrc, stall, immExt, jAddr,
        input  curPC, pcPlus4, nextPC, halted, pcErr, instCount
    );

    modport slave (
        input  PCWre, PCSrc, stall, immExt, jAddr,
        output curPC, pcPlus4, nextPC, halted, pcErr, instCount
    );
endinterface

// File: rtl/next_pc_mux.sv
// rtl/next_pc_mux.sv - combinational next-PC adder, branch/jump target and select
module next_pc_mux
    import cpu_defs_pkg::*;
(
    input  logic [31:0] cur_pc,
    input  logic [1:0]  pc_src,
    input  logic [31:0] imm_ext,
    input  logic [25:0] j_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_target;
    logic [31:0] j_target;

    always_comb begin
        pc_plus4  = cur_pc + 32'd4;
        br_target = pc_plus4 + {imm_ext[29:0], 2'b00};
        j_target  = {pc_plus4[31:28], j_addr, 2'b00};
        case (pc_src)
            PCSRC_BR: next_pc = br_target;
            PCSRC_J:  next_pc = j_target;
            default:  next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register, run/halt state machine and retired-instruction counter
module pc_fetch_unit
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          CNT_W      = 32
) (
    input logic             CLK,
    input logic             Reset,
    pc_fetch_unit_if.slave  bus
);

    state_e           state_q, state_d;
    logic [31:0]      cur_pc_q, cur_pc_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic             pc_err_q, pc_err_d;
    logic [31:0]      pc_plus4;
    logic [31:0]      next_pc;

    next_pc_mux u_next_pc_mux (
        .cur_pc   (cur_pc_q),
        .pc_src   (bus.PCSrc),
        .imm_ext  (bus.immExt),
        .j_addr   (bus.jAddr),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // Inputs are only looked at in RUN, so X driven during BOOT/HALT never reaches the PC.
    always_comb begin
        state_d      = state_q;
        cur_pc_d     = cur_pc_q;
        inst_count_d = inst_count_q;
        pc_err_d     = pc_err_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (bus.PCSrc == PCSRC_RSV) begin
                    pc_err_d = 1'b1;
                end
                if (!bus.stall) begin
                    inst_count_d = (&inst_count_q) ? inst_count_q
                                 : inst_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (bus.PCWre) begin
                        cur_pc_d = next_pc;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q      <= ST_BOOT;
            cur_pc_q     <= RESET_ADDR;
            inst_count_q <= '0;
            pc_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_pc_q     <= cur_pc_d;
            inst_count_q <= inst_count_d;
            pc_err_q     <= pc_err_d;
        end
    end

    assign bus.curPC     = cur_pc_q;
    assign bus.pcPlus4   = pc_plus4;
    assign bus.nextPC    = next_pc;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.pcErr     = pc_err_q;
    assign bus.instCount = inst_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed self-checking bench for pc_fetch_unit
module tb_pc_fetch_unit;
    import cpu_defs_pkg::*;

    logic CLK;
    logic Reset;
    logic rst2;
    int   n_checks;
    int   n_fail;

    pc_fetch_unit_if #(.CNT_W(32)) bus ();
    pc_fetch_unit_if #(.CNT_W(2))  bus2 ();

    pc_fetch_unit #(.RESET_ADDR(32'h0000_0000), .CNT_W(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    pc_fetch_unit #(.RESET_ADDR(32'h0000_0100), .CNT_W(2)) dut_sat (
        .CLK   (CLK),
        .Reset (rst2),
        .bus   (bus2.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.PCWre = 1'b1; bus.PCSrc = PCSRC_SEQ; bus.stall = 1'b0;
        bus.immExt = 32'h0; bus.jAddr = 26'h0;
        step();
        step();
        n_checks++; if (bus.curPC !== 32'h0) begin n_fail++; $display("FAIL reset_curPC got %h exp %h", bus.curPC, 32'h0); end
        n_checks++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b exp 0", bus.halted); end
        n_checks++; if (bus.pcErr !== 1'b0) begin n_fail++; $display("FAIL reset_pcErr got %b exp 0", bus.pcErr); end
        n_checks++; if (bus.instCount !== 32'd0) begin n_fail++; $display("FAIL reset_instCount got %0d exp 0", bus.instCount); end
        n_checks++; if (bus.pcPlus4 !== 32'h4) begin n_fail++; $display("FAIL reset_pcPlus4 got %h exp %h", bus.pcPlus4, 32'h4); end
        Reset = 1'b0;
    endtask

    task automatic test_sequential();
        step();
        n_checks++; if (bus.curPC !== 32'h0 || bus.instCount !== 32'd0) begin n_fail++; $display("FAIL boot_hold got pc %h cnt %0d exp pc 0 cnt 0", bus.curPC, bus.instCount); end
        step();
        n_checks++; if (bus.curPC !== 32'h4) begin n_fail++; $display("FAIL seq_pc1 got %h exp %h", bus.curPC, 32'h4); end
        step();
        n_checks++; if (bus.curPC !== 32'h8) begin n_fail++; $display("FAIL seq_pc2 got %h exp %h", bus.curPC, 32'h8); end
        n_checks++; if (bus.instCount !== 32'd2) begin n_fail++; $display("FAIL seq_cnt got %0d exp 2", bus.instCount); end
    endtask

    task automatic test_branch();
        bus.PCSrc = PCSRC_J; bus.jAddr = 26'h4;
        #1;
        n_checks++; if (bus.nextPC !== 32'h10) begin n_fail++; $display("FAIL jump_nextPC_comb got %h exp %h", bus.nextPC, 32'h10); end
        step();
        n_checks++; if (bus.curPC !== 32'h10) begin n_fail++; $display("FAIL jump_to_10 got %h exp %h", bus.curPC, 32'h10); end
        bus.PCSrc = PCSRC_BR; bus.immExt = 32'hFFFF_FFFE;
        #1;
        n_checks++; if (bus.nextPC !== 32'h0C) begin n_fail++; $display("FAIL br_back_nextPC got %h exp %h", bus.nextPC, 32'h0C); end
        step();
        n_checks++; if (bus.curPC !== 32'h0C) begin n_fail++; $display("FAIL br_back got %h exp %h", bus.curPC, 32'h0C); end
        bus.immExt = 32'h3;
        step();
        n_checks++; if (bus.curPC !== 32'h1C) begin n_fail++; $display("FAIL br_fwd got %h exp %h", bus.curPC, 32'h1C); end
        n_checks++; if (bus.instCount !== 32'd5) begin n_fail++; $display("FAIL br_cnt got %0d exp 5", bus.instCount); end
    endtask

    task automatic test_jump();
        bus.PCSrc = PCSRC_BR; bus.immExt = 32'h0BFF_FFFA;
        step();
        n_checks++; if (bus.curPC !== 32'h3000_0008) begin n_fail++; $display("FAIL br_far got %h exp %h", bus.curPC, 32'h3000_0008); end
        bus.PCSrc = PCSRC_J; bus.jAddr = 26'h000_0040;
        step();
        n_checks++; if (bus.curPC !== 32'h3000_0100) begin n_fail++; $display("FAIL jump_region got %h exp %h", bus.curPC, 32'h3000_0100); end
        n_checks++; if (bus.instCount !== 32'd7) begin n_fail++; $display("FAIL jump_cnt got %0d exp 7", bus.instCount); end
    endtask

    task automatic test_wrap();
        bus.PCSrc = PCSRC_BR; bus.immExt = 32'h33FF_FFBE;
        step();
        n_checks++; if (bus.curPC !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL br_top got %h exp %h", bus.curPC, 32'hFFFF_FFFC); end
        bus.PCSrc = PCSRC_SEQ;
        #1;
        n_checks++; if (bus.pcPlus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pcPlus4 got %h exp 0", bus.pcPlus4); end
        step();
        n_checks++; if (bus.curPC !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", bus.curPC); end
    endtask

    task automatic test_reserved();
        n_checks++; if (bus.pcErr !== 1'b0) begin n_fail++; $display("FAIL err_before got %b exp 0", bus.pcErr); end
        bus.PCSrc = PCSRC_RSV; bus.immExt = 32'h100; bus.jAddr = 26'h3FF;
        #1;
        n_checks++; if (bus.nextPC !== 32'h4) begin n_fail++; $display("FAIL rsv_nextPC got %h exp %h", bus.nextPC, 32'h4); end
        step();
        n_checks++; if (bus.curPC !== 32'h4 || bus.pcErr !== 1'b1) begin n_fail++; $display("FAIL rsv_step got pc %h err %b exp pc 4 err 1", bus.curPC, bus.pcErr); end
        bus.PCSrc = PCSRC_SEQ;
        step();
        n_checks++; if (bus.curPC !== 32'h8 || bus.pcErr !== 1'b1) begin n_fail++; $display("FAIL rsv_sticky got pc %h err %b exp pc 8 err 1", bus.curPC, bus.pcErr); end
        n_checks++; if (bus.instCount !== 32'd11) begin n_fail++; $display("FAIL rsv_cnt got %0d exp 11", bus.instCount); end
    endtask

    task automatic test_stall_halt();
        bus.stall = 1'b1; bus.PCWre = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (bus.curPC !== 32'h8 || bus.instCount !== 32'd11 || bus.halted !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d got pc %h cnt %0d halted %b exp pc 8 cnt 11 halted 0", i, bus.curPC, bus.instCount, bus.halted); end
        end
        bus.stall = 1'b0;
        step();
        n_checks++; if (bus.halted !== 1'b1 || bus.curPC !== 32'h8 || bus.instCount !== 32'd12) begin n_fail++; $display("FAIL halt_take got halted %b pc %h cnt %0d exp 1 8 12", bus.halted, bus.curPC, bus.instCount); end
        bus.PCWre = 1'b1; bus.PCSrc = PCSRC_J; bus.jAddr = 26'h123;
        step();
        step();
        n_checks++; if (bus.curPC !== 32'h8 || bus.instCount !== 32'd12 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_frozen got pc %h cnt %0d halted %b exp 8 12 1", bus.curPC, bus.instCount, bus.halted); end
        bus.PCSrc = 2'bxx; bus.immExt = 'x; bus.PCWre = 1'bx; bus.stall = 1'bx;
        step();
        n_checks++; if (bus.curPC !== 32'h8 || bus.pcErr !== 1'b1) begin n_fail++; $display("FAIL halt_x got pc %h err %b exp 8 1", bus.curPC, bus.pcErr); end
    endtask

    task automatic test_halt_reset();
        bus.PCWre = 1'b1; bus.PCSrc = PCSRC_SEQ; bus.stall = 1'b0; bus.immExt = 32'h0;
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        n_checks++; if (bus.curPC !== 32'h0 || bus.halted !== 1'b0 || bus.instCount !== 32'd0 || bus.pcErr !== 1'b0) begin n_fail++; $display("FAIL halt_reset got pc %h halted %b cnt %0d err %b exp 0 0 0 0", bus.curPC, bus.halted, bus.instCount, bus.pcErr); end
        bus.stall = 1'b1;
        step();
        n_checks++; if (bus.curPC !== 32'h0 || bus.instCount !== 32'd0) begin n_fail++; $display("FAIL boot_stall got pc %h cnt %0d exp 0 0", bus.curPC, bus.instCount); end
        bus.stall = 1'b0;
        step();
        n_checks++; if (bus.curPC !== 32'h4 || bus.instCount !== 32'd1) begin n_fail++; $display("FAIL run_resume got pc %h cnt %0d exp 4 1", bus.curPC, bus.instCount); end
    endtask

    task automatic test_saturate();
        rst2 = 1'b0;
        step();
        n_checks++; if (bus2.curPC !== 32'h100 || bus2.instCount !== 2'd0) begin n_fail++; $display("FAIL sat_boot got pc %h cnt %0d exp 100 0", bus2.curPC, bus2.instCount); end
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (bus2.instCount !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d exp 3", bus2.instCount); end
        n_checks++; if (bus2.curPC !== 32'h114) begin n_fail++; $display("FAIL sat_pc got %h exp %h", bus2.curPC, 32'h114); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst2 = 1'b1;
        bus2.PCWre = 1'b1; bus2.PCSrc = PCSRC_SEQ; bus2.stall = 1'b0;
        bus2.immExt = 32'h0; bus2.jAddr = 26'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_wrap();
        test_reserved();
        test_stall_halt();
        test_halt_reset();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the control unit.
- Holds the architectural PC and drives the instruction-memory address.
- Computes the next PC from the control unit's PCWre/PCSrc and the decoded immediate and jump fields.
- Tracks run/halt state and counts retired instructions for debug.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- PCWre  in  1  from CU; 0 = halt opcode decoded.
- PCSrc  in  2  from CU; 00 = sequential, 01 = branch taken, 10 = jump, 11 = reserved.
- stall  in  1  external hold (debug/memory); freezes PC while high.
- immExt  in  32  sign/zero-extended 16-bit immediate from the extender.
- jAddr  in  26  instruction[25:0].
- curPC  out  32  current PC, instruction-memory address.
- pcPlus4  out  32  curPC+4, combinational.
- nextPC  out  32  selected next PC, combinational.
- halted  out  1  registered; 1 in HALT state.
- pcErr  out  1  registered sticky flag; reserved PCSrc seen.
- instCount  out  CNT_W  registered count of retired instructions.

Behaviour:
- Reset (sync, Reset=1 at CLK edge) sets:
  - curPC=RESET_ADDR, state=BOOT, halted=0, pcErr=0, instCount=0.
  - Reset has priority over every other input, including in HALT and mid-stall.
- Arithmetic: all addition is 32-bit modulo; the carry is dropped, so PC wraps 32'hFFFF_FFFC -> 0.
  - pcPlus4 = curPC + 4.
  - Branch target = pcPlus4 + (immExt << 2); the shift drops the top 2 bits.
  - Jump target = {pcPlus4[31:28], jAddr, 2'b00}.
- nextPC mux:
  - 00 -> pcPlus4.
  - 01 -> branch target.
  - 10 -> jump target.
  - 11 -> pcPlus4, and pcErr is set at the next edge while in RUN. pcErr is sticky until reset.
- State machine (3 states):
  - BOOT: one cycle after reset. PC is held at RESET_ADDR so instruction memory produces its first word. No retirement. Goes to RUN unconditionally, even if stall=1.
  - RUN, stall=1: curPC, instCount and state are all held.
  - RUN, stall=0, PCWre=1: curPC<=nextPC, instCount+1.
  - RUN, stall=0, PCWre=0: curPC held, instCount+1 (the halt instruction retires), state->HALT, halted=1 from that edge.
  - HALT: all inputs except Reset ignored; curPC and instCount frozen. Only Reset leaves HALT.
- stall and PCWre=0 together: stall wins. The halt is taken on the first unstalled cycle.
- instCount saturates at all-ones; it does not wrap.
- Latency: PC update is visible on curPC one cycle after the decision cycle. pcPlus4 and nextPC are combinational from curPC and the inputs.
- X on inputs in BOOT or HALT must not propagate to curPC.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - PCSrc encodings: PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_J=2'b10.
  - State encodings: ST_BOOT, ST_RUN, ST_HALT.
  - HALT_OPCODE=6'b111111, for bench use.
- One natural sub-module, next_pc_mux: the combinational adder/shift/concat/select producing pcPlus4 and nextPC.
- The state machine, PC register and counter stay in pc_fetch_unit.

Test Plan:
- Reset, then 3 cycles with PCSrc=00, PCWre=1 -> curPC sequence 0 (BOOT), 0, 4, 8; instCount=2.
- At curPC=0x10, PCSrc=01, immExt=32'hFFFF_FFFE -> next curPC=0x0C. Then immExt=3 -> curPC=0x0C+4+12=0x1C.
- At curPC=0x3000_0008, PCSrc=10, jAddr=26'h0000040 -> curPC=0x3000_0100.
- stall=1 for 3 cycles together with PCWre=0 -> curPC and instCount held, halted=0. On stall release -> halted=1, instCount+1. Further PCSrc=10 activity -> curPC unchanged.
- In HALT, assert Reset for 1 cycle -> curPC=RESET_ADDR, halted=0, instCount=0, state BOOT; RUN resumes the cycle after.
- PCSrc=11 in RUN -> curPC advances by 4, pcErr=1 and stays 1 after PCSrc returns to 00. Separately, curPC=0xFFFF_FFFC with PCSrc=00 -> wraps to 0.
